// File: rtl/fpu_pkg.sv
// Shared types for the FP32 add/sub pipeline: unpacked operand fields,
// the per-operation record held by the unpack stage, and its occupancy states.
package fpu_pkg;

  localparam int FP_W   = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Widest tag an add_op_t can carry; instances use the low TAG_W bits.
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp_unpacked_t;

  typedef struct packed {
    fp_unpacked_t         a;
    fp_unpacked_t         b;
    logic [EXP_W:0]       exp_diff;
    logic                 a_mag_ge_b;
    logic [TAG_MAX_W-1:0] tag;
  } add_op_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/fpu_classify.sv
// Combinational unpack and classification of one FP32 operand, with optional
// flush of subnormals to a signed zero.
module fpu_classify
  import fpu_pkg::*;
#(
  parameter bit DAZ = 1'b1
) (
  input  logic [FP_W-1:0] fp,
  output fp_unpacked_t    unp
);

  logic [EXP_W-1:0]  exp_raw;
  logic [FRAC_W-1:0] frac_raw;
  logic              exp_zero;
  logic              exp_max;
  logic              frac_zero;
  logic              flush;

  assign exp_raw   = fp[FP_W-2:FRAC_W];
  assign frac_raw  = fp[FRAC_W-1:0];
  assign exp_zero  = (exp_raw == '0);
  assign exp_max   = (exp_raw == EXP_MAX);
  assign frac_zero = (frac_raw == '0);
  assign flush     = DAZ && exp_zero && !frac_zero;

  always_comb begin
    unp         = '0;
    unp.sign    = fp[FP_W-1];
    unp.exp     = exp_raw;
    // A flushed subnormal already has exp 0; only the fraction needs clearing.
    unp.frac    = flush ? '0 : frac_raw;
    unp.is_zero = exp_zero && (frac_zero || DAZ);
    unp.is_inf  = exp_max && frac_zero;
    unp.is_nan  = exp_max && !frac_zero;
  end

endmodule

// File: rtl/fpu_add_unpack_stage.sv
// First stage of the FP32 add/sub unit: unpacks and classifies both operands,
// forms the effective sign of B, exponent difference and magnitude compare.
module fpu_add_unpack_stage
  import fpu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter bit DAZ   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  input  logic              in_sub,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_a,
  output logic              sign_b_eff,
  output logic [7:0]        exp_a,
  output logic [7:0]        exp_b,
  output logic [22:0]       frac_a,
  output logic [22:0]       frac_b,
  output logic              is_zero_a,
  output logic              is_zero_b,
  output logic              is_inf_a,
  output logic              is_inf_b,
  output logic              is_nan_a,
  output logic              is_nan_b,
  output logic [8:0]        exp_diff,
  output logic              a_mag_ge_b,
  output logic [TAG_W-1:0]  out_tag
);

  fp_unpacked_t ua;
  fp_unpacked_t ub_raw;
  fp_unpacked_t ub;
  add_op_t      new_op;
  add_op_t      main_reg;
  add_op_t      skid_reg;
  occ_t         occ_reg;
  logic         in_ready_reg;
  logic         out_valid_reg;
  logic         accept;
  logic         take;
  logic         unused_tag_bits;

  fpu_classify #(.DAZ(DAZ)) u_classify_a (
    .fp  (in_a),
    .unp (ua)
  );

  fpu_classify #(.DAZ(DAZ)) u_classify_b (
    .fp  (in_b),
    .unp (ub_raw)
  );

  // Everything downstream needs is computed here, on the write path.
  always_comb begin
    ub                = ub_raw;
    ub.sign           = ub_raw.sign ^ in_sub;
    new_op            = '0;
    new_op.a          = ua;
    new_op.b          = ub;
    new_op.exp_diff   = {1'b0, ua.exp} - {1'b0, ub.exp};
    new_op.a_mag_ge_b = ({ua.exp, ua.frac} >= {ub.exp, ub.frac});
    new_op.tag        = TAG_MAX_W'(in_tag);
  end

  assign accept = in_valid && in_ready_reg;
  assign take   = out_valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg       <= OCC_EMPTY;
      main_reg      <= '0;
      skid_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (occ_reg)
        OCC_EMPTY: begin
          if (accept) begin
            main_reg      <= new_op;
            occ_reg       <= OCC_ONE;
            out_valid_reg <= 1'b1;
          end
        end
        OCC_ONE: begin
          case ({accept, take})
            2'b11: main_reg <= new_op;
            2'b10: begin
              skid_reg     <= new_op;
              occ_reg      <= OCC_FULL;
              in_ready_reg <= 1'b0;
            end
            2'b01: begin
              occ_reg       <= OCC_EMPTY;
              out_valid_reg <= 1'b0;
            end
            default: ;
          endcase
        end
        OCC_FULL: begin
          // in_ready is low here, so only the promote path is possible.
          if (take) begin
            main_reg     <= skid_reg;
            occ_reg      <= OCC_ONE;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          occ_reg       <= OCC_EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign sign_a     = main_reg.a.sign;
  assign sign_b_eff = main_reg.b.sign;
  assign exp_a      = main_reg.a.exp;
  assign exp_b      = main_reg.b.exp;
  assign frac_a     = main_reg.a.frac;
  assign frac_b     = main_reg.b.frac;
  assign is_zero_a  = main_reg.a.is_zero;
  assign is_zero_b  = main_reg.b.is_zero;
  assign is_inf_a   = main_reg.a.is_inf;
  assign is_inf_b   = main_reg.b.is_inf;
  assign is_nan_a   = main_reg.a.is_nan;
  assign is_nan_b   = main_reg.b.is_nan;
  assign exp_diff   = main_reg.exp_diff;
  assign a_mag_ge_b = main_reg.a_mag_ge_b;
  assign out_tag    = main_reg.tag[TAG_W-1:0];

  assign unused_tag_bits = ^main_reg.tag;

endmodule

// File: tb/tb_fpu_add_unpack_stage.sv
// Self-checking bench for fpu_add_unpack_stage: directed FP32 corner cases plus
// randomized streams against a queue-based reference model.
module tb_fpu_add_unpack_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_sub;
  logic        out_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;

  logic        in_ready, out_valid, sign_a, sign_b_eff;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        is_zero_a, is_zero_b, is_inf_a, is_inf_b, is_nan_a, is_nan_b;
  logic [8:0]  exp_diff;
  logic        a_mag_ge_b;
  logic [3:0]  out_tag;

  logic        z_in_ready, z_out_valid, z_sign_a, z_sign_b_eff;
  logic [7:0]  z_exp_a, z_exp_b;
  logic [22:0] z_frac_a, z_frac_b;
  logic        z_is_zero_a, z_is_zero_b, z_is_inf_a, z_is_inf_b, z_is_nan_a, z_is_nan_b;
  logic [8:0]  z_exp_diff;
  logic        z_a_mag_ge_b;
  logic [3:0]  z_out_tag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_add_unpack_stage #(.TAG_W(4), .DAZ(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_a(sign_a), .sign_b_eff(sign_b_eff), .exp_a(exp_a), .exp_b(exp_b),
    .frac_a(frac_a), .frac_b(frac_b), .is_zero_a(is_zero_a), .is_zero_b(is_zero_b),
    .is_inf_a(is_inf_a), .is_inf_b(is_inf_b), .is_nan_a(is_nan_a), .is_nan_b(is_nan_b),
    .exp_diff(exp_diff), .a_mag_ge_b(a_mag_ge_b), .out_tag(out_tag)
  );

  fpu_add_unpack_stage #(.TAG_W(4), .DAZ(1'b0)) dut_nodaz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(z_out_valid), .out_ready(out_ready),
    .sign_a(z_sign_a), .sign_b_eff(z_sign_b_eff), .exp_a(z_exp_a), .exp_b(z_exp_b),
    .frac_a(z_frac_a), .frac_b(z_frac_b), .is_zero_a(z_is_zero_a), .is_zero_b(z_is_zero_b),
    .is_inf_a(z_is_inf_a), .is_inf_b(z_is_inf_b), .is_nan_a(z_is_nan_a), .is_nan_b(z_is_nan_b),
    .exp_diff(z_exp_diff), .a_mag_ge_b(z_a_mag_ge_b), .out_tag(z_out_tag)
  );

  logic [83:0] obs;
  logic [83:0] z_obs;
  assign obs = {sign_a, exp_a, frac_a, is_zero_a, is_inf_a, is_nan_a,
                sign_b_eff, exp_b, frac_b, is_zero_b, is_inf_b, is_nan_b,
                exp_diff, a_mag_ge_b, out_tag};
  assign z_obs = {z_sign_a, z_exp_a, z_frac_a, z_is_zero_a, z_is_inf_a, z_is_nan_a,
                  z_sign_b_eff, z_exp_b, z_frac_b, z_is_zero_b, z_is_inf_b, z_is_nan_b,
                  z_exp_diff, z_a_mag_ge_b, z_out_tag};

  // Reference: one operand as {sign, exp, frac, zero, inf, nan}.
  function automatic logic [34:0] ref_one(logic [31:0] x, bit daz, bit flip);
    int e;
    int f;
    bit s;
    e = int'(x[30:23]);
    f = int'(x[22:0]);
    s = x[31] ^ flip;
    if (daz && e == 0) f = 0;
    return {s, 8'(e), 23'(f), (e == 0 && f == 0), (e == 255 && f == 0), (e == 255 && f != 0)};
  endfunction

  function automatic logic [83:0] ref_op(logic [31:0] a, logic [31:0] b, bit sub,
                                         logic [3:0] tag, bit daz);
    logic [34:0] ra;
    logic [34:0] rb;
    longint      ma;
    longint      mb;
    int          d;
    logic [8:0]  d9;
    ra = ref_one(a, daz, 1'b0);
    rb = ref_one(b, daz, sub);
    ma = longint'(ra[33:26]) * 64'd8388608 + longint'(ra[25:3]);
    mb = longint'(rb[33:26]) * 64'd8388608 + longint'(rb[25:3]);
    d  = int'(ra[33:26]) - int'(rb[33:26]);
    d9 = d[8:0];
    return {ra, rb, d9, (ma >= mb), tag};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    logic [22:0] f;
    r = $urandom;
    f = 23'($urandom);
    case ($urandom_range(0, 5))
      0: return r;
      1: return {r[31], 31'd0};
      2: return {r[31], 8'd0, f};
      3: return {r[31], 8'hFF, 23'd0};
      4: return {r[31], 8'hFF, f | 23'd1};
      default: return {r[31], 8'($urandom_range(0, 254)), f};
    endcase
  endfunction

  // Presents one op for one cycle with out_ready high; on return it is on out_*.
  task automatic send_one(logic [31:0] a, logic [31:0] b, bit sub, logic [3:0] tag);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_tag = tag; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (obs !== 84'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", obs); end
  endtask

  task automatic test_basic();
    send_one(32'h3F800000, 32'h40000000, 1'b0, 4'd5);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (exp_a !== 8'h7F || exp_b !== 8'h80) begin errors++; $display("FAIL basic_exp got=%h/%h exp=7f/80", exp_a, exp_b); end
    checks++; if (exp_diff !== 9'h1FF) begin errors++; $display("FAIL basic_diff got=%h exp=1ff", exp_diff); end
    checks++; if (a_mag_ge_b !== 1'b0 || out_tag !== 4'd5) begin errors++; $display("FAIL basic_ge_tag got=%b/%h exp=0/5", a_mag_ge_b, out_tag); end
    checks++; if (obs !== ref_op(32'h3F800000, 32'h40000000, 1'b0, 4'd5, 1'b1)) begin errors++; $display("FAIL basic_model got=%h", obs); end
  endtask

  task automatic test_inf();
    send_one(32'h7F800000, 32'h7F800000, 1'b1, 4'd2);
    checks++; if ({is_inf_a, is_inf_b, sign_b_eff} !== 3'b111) begin errors++; $display("FAIL inf_flags got=%b exp=111", {is_inf_a, is_inf_b, sign_b_eff}); end
    checks++; if (obs !== ref_op(32'h7F800000, 32'h7F800000, 1'b1, 4'd2, 1'b1)) begin errors++; $display("FAIL inf_model got=%h", obs); end
  endtask

  task automatic test_daz();
    send_one(32'h00000001, 32'h3F800000, 1'b0, 4'd3);
    checks++; if ({is_zero_a, exp_a, frac_a} !== {1'b1, 8'd0, 23'd0}) begin errors++; $display("FAIL daz_flush got=%b/%h/%h exp=1/0/0", is_zero_a, exp_a, frac_a); end
    checks++; if (z_is_zero_a !== 1'b0 || z_frac_a !== 23'h000001) begin errors++; $display("FAIL nodaz_sub got=%b/%h exp=0/000001", z_is_zero_a, z_frac_a); end
    checks++; if (z_obs !== ref_op(32'h00000001, 32'h3F800000, 1'b0, 4'd3, 1'b0)) begin errors++; $display("FAIL nodaz_model got=%h", z_obs); end
    send_one(32'h80000010, 32'h00400000, 1'b0, 4'd4);
    checks++; if ({sign_a, is_zero_a, is_zero_b, frac_b} !== {1'b1, 1'b1, 1'b1, 23'd0}) begin errors++; $display("FAIL daz_sign got=%b%b%b/%h exp=111/0", sign_a, is_zero_a, is_zero_b, frac_b); end
    checks++; if (obs !== ref_op(32'h80000010, 32'h00400000, 1'b0, 4'd4, 1'b1)) begin errors++; $display("FAIL daz_model got=%h", obs); end
  endtask

  task automatic test_nan_zero();
    send_one(32'h7FC00000, 32'h80000000, 1'b0, 4'd6);
    checks++; if ({is_nan_a, is_zero_b, sign_b_eff} !== 3'b111) begin errors++; $display("FAIL nan_zero got=%b exp=111", {is_nan_a, is_zero_b, sign_b_eff}); end
    send_one(32'h80000000, 32'h00000000, 1'b1, 4'd7);
    checks++; if (sign_b_eff !== 1'b1 || a_mag_ge_b !== 1'b1) begin errors++; $display("FAIL zero_sub got=%b/%b exp=1/1", sign_b_eff, a_mag_ge_b); end
  endtask

  // Stream n ops; rnd=0 stalls out_ready on cycles 2-4, rnd=1 randomizes both sides.
  task automatic run_stream(int n, bit rnd);
    logic [83:0] q[$];
    int          sent = 0;
    int          recv = 0;
    int          cyc = 0;
    bit          pend = 0;
    bit          exp_ir;
    bit          exp_ov;
    logic [31:0] ca = '0;
    logic [31:0] cb = '0;
    bit          cs = 0;
    while (recv < n && cyc < n * 10 + 50) begin
      @(negedge clk);
      exp_ir = (q.size() < 2);
      exp_ov = (q.size() > 0);
      checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ir); end
      checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL stream_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_ov); end
      if (exp_ov) begin
        checks++; if (obs !== q[0]) begin errors++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, obs, q[0]); end
      end
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 2 && cyc <= 4);
      if (!pend && sent < n && (!rnd || $urandom_range(0, 4) != 0)) begin
        pend = 1;
        ca = rand_fp();
        cb = ($urandom_range(0, 7) == 0) ? ca : rand_fp();
        cs = 1'($urandom);
      end
      in_valid = pend; in_a = ca; in_b = cb; in_sub = cs; in_tag = sent[3:0];
      if (exp_ov && out_ready) begin void'(q.pop_front()); recv++; end
      if (pend && exp_ir) begin q.push_back(ref_op(ca, cb, cs, sent[3:0], 1'b1)); sent++; pend = 0; end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (recv != n) begin errors++; $display("FAIL stream_timeout got=%0d exp=%0d", recv, n); end
  endtask

  task automatic test_stream();
    run_stream(8, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_stream(300, 1'b1);
  endtask

  task automatic test_reset_full();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 32'h40400000; in_b = 32'h3F000000; in_sub = 1'b0; in_tag = 4'd1;
    @(negedge clk);
    in_a = 32'hC0000000; in_tag = 4'd2;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL full_state got=%b/%b exp=0/1", in_ready, out_valid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL full_reset got=%b/%b exp=0/1", out_valid, in_ready); end
    send_one(32'h41200000, 32'hC1200000, 1'b1, 4'd9);
    checks++; if (out_valid !== 1'b1 || obs !== ref_op(32'h41200000, 32'hC1200000, 1'b1, 4'd9, 1'b1)) begin errors++; $display("FAIL after_reset got=%b/%h", out_valid, obs); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL after_reset_drain got=%b exp=0", out_valid); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_inf();
    test_daz();
    test_nan_zero();
    @(negedge clk);
    test_stream();
    test_back_to_back();
    test_reset_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
